regfile_dump_reader: RTL and testbench

- Debug-side reader for the ID-stage register bank. It walks every register through a spare read port.
- On i_start, each 32-bit word is serialised into bytes, LSB first, on a valid/ready byte stream. The stream feeds the debug UART transmitter.
- Used by the debug unit to dump processor state after halt or step.
- Never writes the bank.

---
 rtl/regfile_dump_pkg.sv | 24 ++
 rtl/regfile_dump_reader_serializer.sv | 54 +++++
 rtl/regfile_dump_reader.sv | 122 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared FSM encoding and default geometry for the register-bank dump reader.
// Defaults match the ID-stage register bank (32 x 32-bit words, 8-bit bytes).
package regfile_dump_pkg;

    localparam int NB_DATA_DEF    = 32;
    localparam int NB_REG_DEF     = 5;
    localparam int SIZE_REG_DEF   = 32;
    localparam int NB_BYTE_DEF    = 8;
    localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // A one-byte word still needs a 1-bit counter to stay a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Loads one word and emits it LSB-byte first; valid rises the cycle after i_load.
// Valid/ready: byte and valid held until accepted, valid drops after the last byte.
module word_byte_serializer
    import regfile_dump_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_last_accept
);

    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_CNT = cnt_width(BPW);

    logic [NB_DATA-1:0] r_shift;
    logic [NB_CNT-1:0]  r_cnt;
    logic               r_valid;
    logic               w_hs;
    logic               w_last;

    assign w_hs          = r_valid && i_tx_ready;
    assign w_last        = (r_cnt == NB_CNT'(BPW - 1));
    assign o_last_accept = w_hs && w_last;
    assign o_tx_data     = r_shift[NB_BYTE-1:0];
    assign o_tx_valid    = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_shift <= r_shift >> NB_BYTE;
            if (w_last) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register bank and streams every word LSB-byte first; first byte 2 cycles after i_start, stalls on i_tx_ready.
// REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_REG   = NB_REG_DEF,
    parameter int SIZE_REG = SIZE_REG_DEF,
    parameter int NB_BYTE  = NB_BYTE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_REG-1:0]  o_rd_address,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    state_t             r_state;
    logic [NB_REG:0]    r_word;
    logic               r_busy;
    logic               r_done;
    logic               w_load;
    logic               w_last_accept;
    logic [NB_BYTE-1:0] w_ser_data;
    logic               w_ser_valid;

    assign w_load       = (r_state == ST_READ);
    assign o_rd_address = r_word[NB_REG-1:0];
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (w_load),
        .i_word        (i_rd_data),
        .i_tx_ready    (i_tx_ready),
        .o_tx_data     (w_ser_data),
        .o_tx_valid    (w_ser_valid),
        .o_last_accept (w_last_accept)
    );

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_csum <= '0;
        end else if (r_state == ST_SEND && w_ser_valid && i_tx_ready) begin
            r_csum <= r_csum ^ w_ser_data;
        end
    end

    assign o_tx_data  = (r_state == ST_CSUM) ? r_csum : w_ser_data;
    assign o_tx_valid = w_ser_valid || (r_state == ST_CSUM);
`else
    assign o_tx_data  = w_ser_data;
    assign o_tx_valid = w_ser_valid;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_word  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_last_accept) begin
                        if (r_word == (NB_REG+1)'(SIZE_REG - 1)) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_word  <= r_word + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (i_tx_ready) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    r_word  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; checksum checks follow REGFILE_DUMP_CHECKSUM_EN.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] bank [32];
    assign rd_data = bank[rd_address];

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .o_rd_address (rd_address),
        .i_rd_data    (rd_data),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int N_BYTES   = 129;
    localparam int DONE_EDGE = 162;
`else
    localparam int N_BYTES   = 128;
    localparam int DONE_EDGE = 161;
`endif

    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int done_cnt, stable_err, first_valid_edge, done_edge, rst_edge;
    bit timed_out, busy_after, post_reset_valid, post_reset_busy, post_reset_seen;

    // Expected stream straight from the bank contents, plus trailing XOR when enabled.
    function automatic void build_exp();
        logic [7:0] x;
        logic [31:0] w;
        x = 8'h00;
        exp_q.delete();
        for (int k = 0; k < 32; k++) begin
            w = bank[k];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    // Pulses start, then records accepted bytes, done pulses and stall stability.
    task automatic collect(input int duty, input int start_inj, input int reset_at, input int max_edges);
        bit         prev_stall;
        logic [7:0] prev_dat;
        bit         injected;
        bit         rst_hit;
        got.delete();
        done_cnt = 0; stable_err = 0; first_valid_edge = -1; done_edge = -1; rst_edge = -1;
        timed_out = 0; busy_after = 1; post_reset_valid = 1; post_reset_busy = 1; post_reset_seen = 0;
        prev_stall = 0; prev_dat = 8'h00; injected = 0; rst_hit = 0;
        start = 1'b1;
        for (int e = 1; e <= max_edges; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
            if (rst_hit && !post_reset_seen) begin
                post_reset_valid = tx_valid;
                post_reset_busy  = busy;
                post_reset_seen  = 1;
            end
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (tx_valid && first_valid_edge < 0) first_valid_edge = e;
            if (prev_stall && (!tx_valid || tx_data !== prev_dat)) stable_err++;
            if (done_edge >= 0 && e > done_edge) begin
                busy_after = busy;
                return;
            end
            if (rst_hit && e >= rst_edge + 4) return;
            tx_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            if (!injected && start_inj >= 0 && got.size() == start_inj && tx_valid) begin
                start = 1'b1;
                injected = 1;
            end
            if (!rst_hit && reset_at >= 0 && got.size() == reset_at && tx_valid) begin
                rst = 1'b1;
                tx_ready = 1'b0;
                rst_hit = 1;
                rst_edge = e;
            end
            prev_stall = tx_valid && !tx_ready && !rst;
            prev_dat   = tx_data;
            if (tx_valid && tx_ready) got.push_back(tx_data);
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        n_checks++; if (rd_address !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", rd_address); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_dump_no_stall();
        logic [7:0] g;
        for (int k = 0; k < 32; k++) bank[k] = 32'hA0B0C0D0 + k;
        build_exp();
        collect(100, -1, -1, 2000);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL nostall_timeout got=1 exp=0"); end
        n_checks++; if (got.size() != N_BYTES) begin n_fail++; $display("FAIL nostall_count got=%0d exp=%0d", got.size(), N_BYTES); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL nostall_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
        n_checks++; if (first_valid_edge != 2) begin n_fail++; $display("FAIL nostall_first_valid got=%0d exp=2", first_valid_edge); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL nostall_done_cnt got=%0d exp=1", done_cnt); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL nostall_busy_after got=%b exp=0", busy_after); end
    endtask

    task automatic test_random_ready();
        logic [7:0] g;
        build_exp();
        collect(30, -1, -1, 5000);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL rnd_timeout got=1 exp=0"); end
        n_checks++; if (got.size() != N_BYTES) begin n_fail++; $display("FAIL rnd_count got=%0d exp=%0d", got.size(), N_BYTES); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
        n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL rnd_stall_stability got=%0d exp=0", stable_err); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rnd_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] g;
        build_exp();
        collect(100, 10, -1, 2000);
        n_checks++; if (got.size() != N_BYTES) begin n_fail++; $display("FAIL restart_count got=%0d exp=%0d", got.size(), N_BYTES); end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL restart_byte[%0d] got=%h exp=%h", i, g, exp_q[i]); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
        n_checks++; if (done_edge != DONE_EDGE) begin n_fail++; $display("FAIL restart_done_edge got=%0d exp=%0d", done_edge, DONE_EDGE); end
    endtask

    task automatic test_reset_mid_dump();
        logic [7:0] g;
        build_exp();
        collect(100, -1, 50, 2000);
        n_checks++; if (!post_reset_seen) begin n_fail++; $display("FAIL midrst_reached got=0 exp=1"); end
        n_checks++; if (post_reset_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", post_reset_valid); end
        n_checks++; if (post_reset_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", post_reset_busy); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL midrst_done_cnt got=%0d exp=0", done_cnt); end
        n_checks++; if (got.size() != 50) begin n_fail++; $display("FAIL midrst_partial got=%0d exp=50", got.size()); end
        collect(100, -1, -1, 2000);
        g = (got.size() > 0) ? got[0] : 8'hxx;
        n_checks++; if (g !== 8'hD0) begin n_fail++; $display("FAIL midrst_restart_first got=%h exp=d0", g); end
        n_checks++; if (got.size() != N_BYTES) begin n_fail++; $display("FAIL midrst_restart_count got=%0d exp=%0d", got.size(), N_BYTES); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL midrst_restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_all_ones();
        int ones;
        for (int k = 0; k < 32; k++) bank[k] = 32'hFFFFFFFF;
        collect(100, -1, -1, 2000);
        ones = 0;
        for (int i = 0; i < 128 && i < got.size(); i++) if (got[i] === 8'hFF) ones++;
        n_checks++; if (ones != 128) begin n_fail++; $display("FAIL ones_bytes got=%0d exp=128", ones); end
        n_checks++; if (done_edge != DONE_EDGE) begin n_fail++; $display("FAIL ones_cycles got=%0d exp=%0d", done_edge, DONE_EDGE); end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        n_checks++; if (got.size() != 129 || got[128] !== 8'h00) begin n_fail++; $display("FAIL ones_csum size=%0d exp=00", got.size()); end
`endif
    endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] g;
        for (int k = 0; k < 32; k++) bank[k] = k;
        collect(100, -1, -1, 2000);
        g = (got.size() == 129) ? got[128] : 8'hxx;
        n_checks++; if (g !== 8'h00) begin n_fail++; $display("FAIL csum_byte got=%h exp=00", g); end
        n_checks++; if (done_edge != 162) begin n_fail++; $display("FAIL csum_done_edge got=%0d exp=162", done_edge); end
        for (int k = 0; k < 32; k++) bank[k] = 32'h0 + (k == 3 ? 32'h0000_5A00 : 32'h0);
        collect(40, -1, -1, 5000);
        g = (got.size() == 129) ? got[128] : 8'hxx;
        n_checks++; if (g !== 8'h5A) begin n_fail++; $display("FAIL csum_single got=%h exp=5a", g); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        for (int k = 0; k < 32; k++) bank[k] = 32'h0;
        test_reset();
        test_dump_no_stall();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid_dump();
        test_all_ones();
`ifdef REGFILE_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
